// File: rtl/ocp_sram_slave.sv
// OCP slave endpoint: turns one OCP read/write at a time into a single-port
// synchronous SRAM access, with programmable wait states and range checking.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module ocp_sram_slave #(
  parameter int MEM_AW      = 14,
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [`ADDR_WIDTH-1:0]  i_MAddr,
  input  logic [2:0]              i_MCmd,
  input  logic [`DATA_WIDTH-1:0]  i_MData,
  input  logic [`BEN_WIDTH-1:0]   i_MByteEn,
  output logic                    o_SCmdAccept,
  output logic [`DATA_WIDTH-1:0]  o_SData,
  output logic [1:0]              o_SResp,
  output logic                    o_mem_ce,
  output logic                    o_mem_we,
  output logic [MEM_AW-1:0]       o_mem_addr,
  output logic [`BEN_WIDTH-1:0]   o_mem_ben,
  output logic [`DATA_WIDTH-1:0]  o_mem_wdata,
  input  logic [`DATA_WIDTH-1:0]  i_mem_rdata
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int BW = `BEN_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DATA, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]     ben_q, ben_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        sresp_q, sresp_d;
  logic [DW-1:0]     sdata_q, sdata_d;

  logic [AW-1:0]     word_idx;
  logic              range_ok;
  logic              cmd_ok;
  logic              addr_lsb_unused;

  // Byte offset within the word plays no part in the SRAM access.
  assign word_idx        = {2'b00, i_MAddr[AW-1:2]};
  assign addr_lsb_unused = ^i_MAddr[1:0];
  assign range_ok        = word_idx < AW'(MEM_WORDS);
  assign cmd_ok          = (i_MCmd == `OCP_CMD_WRITE) || (i_MCmd == `OCP_CMD_READ);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      sresp_q <= `OCP_RESP_NULL;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      sresp_q <= sresp_d;
      sdata_q <= sdata_d;
    end
  end

  // Response and read data are registered on the transition into RESP so
  // they are valid for exactly the one RESP cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    sresp_d = `OCP_RESP_NULL;
    sdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (i_MCmd != `OCP_CMD_IDLE) begin
          cmd_d   = i_MCmd;
          addr_d  = word_idx[MEM_AW-1:0];
          wdata_d = i_MData;
          ben_d   = i_MByteEn;
          if (!cmd_ok || !range_ok) begin
            state_d = S_RESP;
            sresp_d = `OCP_RESP_ERR;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cmd_q == `OCP_CMD_READ) begin
          rdata_d = i_mem_rdata;
        end
        if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = S_RESP;
          sresp_d = `OCP_RESP_DVA;
          if (cmd_q == `OCP_CMD_READ) begin
            sdata_d = i_mem_rdata;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          sresp_d = `OCP_RESP_DVA;
          if (cmd_q == `OCP_CMD_READ) begin
            sdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_SCmdAccept = (state_q == S_IDLE) || (i_MCmd == `OCP_CMD_IDLE);
  assign o_SResp      = sresp_q;
  assign o_SData      = sdata_q;
  assign o_mem_ce     = (state_q == S_ACC);
  assign o_mem_we     = (state_q == S_ACC) && (cmd_q == `OCP_CMD_WRITE);
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_ben    = (cmd_q == `OCP_CMD_WRITE) ? ben_q : '0;

endmodule

// File: tb/tb_ocp_sram_slave.sv
// Directed self-checking bench for ocp_sram_slave: one instance without wait
// states, one with three, each backed by a small behavioural SRAM.
module tb_ocp_sram_slave;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [1:0] R_NULL   = 2'b00;
  localparam logic [1:0] R_DVA    = 2'b01;
  localparam logic [1:0] R_ERR    = 2'b11;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] maddr   [2];
  logic [2:0]  mcmd    [2];
  logic [31:0] mdata   [2];
  logic [3:0]  mben    [2];
  logic        accept  [2];
  logic [31:0] sdata   [2];
  logic [1:0]  sresp   [2];
  logic        ce      [2];
  logic        we      [2];
  logic [13:0] mem_a   [2];
  logic [3:0]  mem_b   [2];
  logic [31:0] mem_wd  [2];
  logic [31:0] mem_rd  [2];
  logic [31:0] mem     [2][16384];
  int          ce_cnt  [2] = '{0, 0};
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  ocp_sram_slave #(.MEM_AW(14), .MEM_WORDS(16384), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .i_MAddr(maddr[0]), .i_MCmd(mcmd[0]), .i_MData(mdata[0]),
    .i_MByteEn(mben[0]), .o_SCmdAccept(accept[0]), .o_SData(sdata[0]), .o_SResp(sresp[0]),
    .o_mem_ce(ce[0]), .o_mem_we(we[0]), .o_mem_addr(mem_a[0]), .o_mem_ben(mem_b[0]),
    .o_mem_wdata(mem_wd[0]), .i_mem_rdata(mem_rd[0]));

  ocp_sram_slave #(.MEM_AW(14), .MEM_WORDS(16384), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .nrst(nrst), .i_MAddr(maddr[1]), .i_MCmd(mcmd[1]), .i_MData(mdata[1]),
    .i_MByteEn(mben[1]), .o_SCmdAccept(accept[1]), .o_SData(sdata[1]), .o_SResp(sresp[1]),
    .o_mem_ce(ce[1]), .o_mem_we(we[1]), .o_mem_addr(mem_a[1]), .o_mem_ben(mem_b[1]),
    .o_mem_wdata(mem_wd[1]), .i_mem_rdata(mem_rd[1]));

  // Synchronous SRAM: read-first, one cycle read latency, per-byte writes.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (ce[p] === 1'b1) begin
        ce_cnt[p] <= ce_cnt[p] + 1;
        mem_rd[p] <= mem[p][mem_a[p]];
        if (we[p] === 1'b1) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_b[p][b]) mem[p][mem_a[p]][8*b +: 8] <= mem_wd[p][8*b +: 8];
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat counts cycles from the accept edge to the response cycle.
  task automatic txn(input int p, input logic [2:0] cmd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     output logic [1:0] resp, output logic [31:0] rd, output int lat,
                     output logic [31:0] pre_d, output logic [1:0] post_r,
                     output logic [31:0] post_d);
    int w;
    mcmd[p] = cmd; maddr[p] = a; mdata[p] = d; mben[p] = b;
    #1;
    w = 0;
    while (accept[p] !== 1'b1 && w < 20) begin tick; w++; end
    pre_d = sdata[p];
    tick;
    mcmd[p] = CMD_IDLE;
    lat = 1;
    while (sresp[p] === R_NULL && lat < 30) begin
      pre_d = sdata[p];
      tick;
      lat++;
    end
    resp = sresp[p];
    rd   = sdata[p];
    tick;
    post_r = sresp[p];
    post_d = sdata[p];
  endtask

  initial begin
    logic [1:0]  resp, post_r;
    logic [31:0] rd, pre_d, post_d;
    int          lat, c0, w;

    for (int p = 0; p < 2; p++) begin
      mcmd[p] = CMD_IDLE; maddr[p] = '0; mdata[p] = '0; mben[p] = '0;
    end
    nrst = 1'b0;

    // Reset held while the master presents a write
    mcmd[0] = CMD_WR; maddr[0] = 32'h10; mdata[0] = 32'h55AA55AA; mben[0] = 4'hF;
    repeat (3) tick;
    chk("rst_sresp",  32'(sresp[0]), 32'(R_NULL));
    chk("rst_accept", 32'(accept[0]), 32'd1);
    chk("rst_ce",     32'(ce[0]), 32'd0);
    chk("rst_we",     32'(we[0]), 32'd0);
    chk("rst_sdata",  sdata[0], 32'h0);
    chk("rst_memaddr", 32'(mem_a[0]), 32'h0);
    chk("rst_cecnt",  32'(ce_cnt[0]), 32'd0);
    mcmd[0] = CMD_IDLE;
    tick;
    nrst = 1'b1;
    tick;

    // Full-word write, cycle by cycle
    mcmd[0] = CMD_WR; maddr[0] = 32'h10; mdata[0] = 32'hDEADBEEF; mben[0] = 4'hF;
    #1;
    chk("wr_accept", 32'(accept[0]), 32'd1);
    tick;
    mcmd[0] = CMD_IDLE;
    chk("wr_acc_ce",    32'(ce[0]), 32'd1);
    chk("wr_acc_we",    32'(we[0]), 32'd1);
    chk("wr_acc_addr",  32'(mem_a[0]), 32'd4);
    chk("wr_acc_ben",   32'(mem_b[0]), 32'hF);
    chk("wr_acc_wdata", mem_wd[0], 32'hDEADBEEF);
    chk("wr_acc_sresp", 32'(sresp[0]), 32'(R_NULL));
    tick;
    chk("wr_data_ce",    32'(ce[0]), 32'd0);
    chk("wr_data_sresp", 32'(sresp[0]), 32'(R_NULL));
    tick;
    chk("wr_resp",       32'(sresp[0]), 32'(R_DVA));
    chk("wr_resp_sdata", sdata[0], 32'h0);
    tick;
    chk("wr_post_sresp", 32'(sresp[0]), 32'(R_NULL));

    // Partial write then read-back merge
    txn(0, CMD_WR, 32'h10, 32'h12345678, 4'b0011, resp, rd, lat, pre_d, post_r, post_d);
    chk("pwr_resp", 32'(resp), 32'(R_DVA));
    chk("pwr_lat",  32'(lat), 32'd3);
    txn(0, CMD_RD, 32'h10, 32'h0, 4'h0, resp, rd, lat, pre_d, post_r, post_d);
    chk("rd_resp",   32'(resp), 32'(R_DVA));
    chk("rd_data",   rd, 32'hDEAD5678);
    chk("rd_lat",    32'(lat), 32'd3);
    chk("rd_pre",    pre_d, 32'h0);
    chk("rd_post_d", post_d, 32'h0);
    chk("rd_post_r", 32'(post_r), 32'(R_NULL));

    // Zero byte-enable write changes nothing; low address bits ignored
    txn(0, CMD_WR, 32'h10, 32'hFFFFFFFF, 4'b0000, resp, rd, lat, pre_d, post_r, post_d);
    chk("ben0_resp", 32'(resp), 32'(R_DVA));
    txn(0, CMD_RD, 32'h13, 32'h0, 4'h0, resp, rd, lat, pre_d, post_r, post_d);
    chk("ben0_data", rd, 32'hDEAD5678);

    // Out-of-range and illegal command return ERR without touching SRAM
    c0 = ce_cnt[0];
    txn(0, CMD_RD, 32'h10000, 32'h0, 4'h0, resp, rd, lat, pre_d, post_r, post_d);
    chk("oor_resp",  32'(resp), 32'(R_ERR));
    chk("oor_lat",   32'(lat), 32'd1);
    chk("oor_sdata", rd, 32'h0);
    txn(0, 3'b111, 32'h10, 32'h0, 4'hF, resp, rd, lat, pre_d, post_r, post_d);
    chk("bad_resp",  32'(resp), 32'(R_ERR));
    chk("bad_lat",   32'(lat), 32'd1);
    chk("bad_post",  32'(post_r), 32'(R_NULL));
    chk("err_no_ce", 32'(ce_cnt[0] - c0), 32'd0);

    // Last implemented word is in range
    txn(0, CMD_WR, 32'hFFFC, 32'h0BADF00D, 4'hF, resp, rd, lat, pre_d, post_r, post_d);
    chk("top_wr_resp", 32'(resp), 32'(R_DVA));
    txn(0, CMD_RD, 32'hFFFC, 32'h0, 4'h0, resp, rd, lat, pre_d, post_r, post_d);
    chk("top_rd_data", rd, 32'h0BADF00D);

    // Three wait states, with a second read held while busy
    txn(1, CMD_WR, 32'h8, 32'hA5A5A5A5, 4'hF, resp, rd, lat, pre_d, post_r, post_d);
    chk("ws_wr_lat", 32'(lat), 32'd6);
    mcmd[1] = CMD_RD; maddr[1] = 32'h8;
    #1;
    chk("ws_accept0", 32'(accept[1]), 32'd1);
    tick;
    for (int i = 0; i <= 6; i++) begin
      chk($sformatf("ws_acc_%0d", i), 32'(accept[1]), (i == 6) ? 32'd1 : 32'd0);
      chk($sformatf("ws_resp_%0d", i), 32'(sresp[1]), (i == 5) ? 32'(R_DVA) : 32'(R_NULL));
      if (i == 5) chk("ws_rd_data", sdata[1], 32'hA5A5A5A5);
      if (i < 6) tick;
    end
    tick;
    mcmd[1] = CMD_IDLE;
    chk("ws_2nd_ce", 32'(ce[1]), 32'd1);
    w = 0;
    while (sresp[1] === R_NULL && w < 20) begin tick; w++; end
    chk("ws_2nd_lat",  32'(w), 32'd5);
    chk("ws_2nd_resp", 32'(sresp[1]), 32'(R_DVA));
    chk("ws_2nd_data", sdata[1], 32'hA5A5A5A5);
    tick;

    // Reset during the ACC cycle of a write
    txn(0, CMD_WR, 32'h20, 32'hCAFEF00D, 4'hF, resp, rd, lat, pre_d, post_r, post_d);
    chk("old_wr_resp", 32'(resp), 32'(R_DVA));
    mcmd[0] = CMD_WR; maddr[0] = 32'h20; mdata[0] = 32'h11111111; mben[0] = 4'hF;
    #1;
    tick;
    mcmd[0] = CMD_IDLE;
    chk("mid_ce", 32'(ce[0]), 32'd1);
    #1;
    nrst = 1'b0;
    #1;
    chk("mid_rst_ce",    32'(ce[0]), 32'd0);
    chk("mid_rst_we",    32'(we[0]), 32'd0);
    chk("mid_rst_sresp", 32'(sresp[0]), 32'(R_NULL));
    tick;
    nrst = 1'b1;
    tick;
    chk("mid_post1", 32'(sresp[0]), 32'(R_NULL));
    tick;
    chk("mid_post2", 32'(sresp[0]), 32'(R_NULL));
    txn(0, CMD_RD, 32'h20, 32'h0, 4'h0, resp, rd, lat, pre_d, post_r, post_d);
    chk("mid_rd_resp", 32'(resp), 32'(R_DVA));
    chk("mid_rd_data", rd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
